// File: rtl/cordic_quad_restore_if.sv
// Bundle of tag-push, result-in and corrected-result-out signals for
// cordic_quad_restore. The CORDIC_QUAD_LEVEL_EN macro adds tag_level/err_clr.
//
// Handshake: tag_valid and res_valid are single-cycle strobes with no
// back-pressure; each high cycle is one event. out_valid is a one-cycle
// pulse per accepted result; the data outputs hold while it is low.
interface cordic_quad_restore_if #(
    parameter int W     = 24,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic           tag_valid;
    logic [1:0]     tag_quad;
    logic           res_valid;
    logic [W-1:0]   cos_in;
    logic [W-1:0]   sin_in;
    logic           out_valid;
    logic [W-1:0]   cos_out;
    logic [W-1:0]   sin_out;
    logic [1:0]     quad_out;
    logic           tag_full;
    logic           err_overflow;
    logic           err_underflow;
`ifdef CORDIC_QUAD_LEVEL_EN
    logic [AW:0]    tag_level;
    logic           err_clr;

    modport master (
        output tag_valid, tag_quad, res_valid, cos_in, sin_in, err_clr,
        input  out_valid, cos_out, sin_out, quad_out, tag_full,
               err_overflow, err_underflow, tag_level
    );
    modport slave (
        input  tag_valid, tag_quad, res_valid, cos_in, sin_in, err_clr,
        output out_valid, cos_out, sin_out, quad_out, tag_full,
               err_overflow, err_underflow, tag_level
    );
`else
    modport master (
        output tag_valid, tag_quad, res_valid, cos_in, sin_in,
        input  out_valid, cos_out, sin_out, quad_out, tag_full,
               err_overflow, err_underflow
    );
    modport slave (
        input  tag_valid, tag_quad, res_valid, cos_in, sin_in,
        output out_valid, cos_out, sin_out, quad_out, tag_full,
               err_overflow, err_underflow
    );
`endif
endinterface

// File: rtl/cordic_quad_restore.sv
// cordic_quad_restore: queues the quadrant tag of each reduced angle and
// applies the matching sign correction to each CORDIC cos/sin result.
// Optional macro CORDIC_QUAD_LEVEL_EN exposes the FIFO level (tag_level)
// and a clear input (err_clr) for the sticky error flags.
module cordic_quad_restore #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_quad_restore_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_out_valid;
    logic [W-1:0]  r_cos;
    logic [W-1:0]  r_sin;
    logic [1:0]    r_quad;
    logic          r_full;
    logic          r_ovf;
    logic          r_unf;

    logic          w_pop;
    logic          w_push;
    logic          w_drop_push;
    logic          w_drop_res;
    logic          w_clr;
    logic [1:0]    w_q;
    logic [AW:0]   w_count_next;
    logic [W-1:0]  w_cos_corr;
    logic [W-1:0]  w_sin_corr;

    // Two's complement negation that maps the most negative code to the
    // most positive one instead of wrapping back onto itself.
    function automatic logic [W-1:0] neg_sat(input logic [W-1:0] x);
        return (x == MOST_NEG) ? MOST_POS : (~x + 1'b1);
    endfunction

    // Push/pop decisions, next count and sign correction of the popped tag.
    always_comb begin
        w_pop        = bus.res_valid && (r_count != '0);
        w_push       = bus.tag_valid && ((r_count != FULL_CNT) || w_pop);
        w_drop_push  = bus.tag_valid && !w_push;
        w_drop_res   = bus.res_valid && !w_pop;
        w_q          = r_mem[r_rd_ptr];
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
        // Bit 0 of the tag flips cosine, bit 1 flips sine.
        w_cos_corr   = w_q[0] ? neg_sat(bus.cos_in) : bus.cos_in;
        w_sin_corr   = w_q[1] ? neg_sat(bus.sin_in) : bus.sin_in;
`ifdef CORDIC_QUAD_LEVEL_EN
        w_clr        = bus.err_clr;
`else
        w_clr        = 1'b0;
`endif
    end

    // Tag storage; stale entries are harmless because count gates reads.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= bus.tag_quad;
        end
    end

    // Pointers, count, registered outputs and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_quad      <= 2'b00;
            r_full      <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            // Pointers are AW bits wide, so increment wraps modulo DEPTH.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_next;
            r_full      <= (w_count_next == FULL_CNT);
            r_out_valid <= w_pop;
            if (w_pop) begin
                r_cos  <= w_cos_corr;
                r_sin  <= w_sin_corr;
                r_quad <= w_q;
            end
            // A clear and a new error in the same cycle leaves the flag set.
            r_ovf <= (r_ovf && !w_clr) || w_drop_push;
            r_unf <= (r_unf && !w_clr) || w_drop_res;
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.cos_out       = r_cos;
    assign bus.sin_out       = r_sin;
    assign bus.quad_out      = r_quad;
    assign bus.tag_full      = r_full;
    assign bus.err_overflow  = r_ovf;
    assign bus.err_underflow = r_unf;
`ifdef CORDIC_QUAD_LEVEL_EN
    assign bus.tag_level     = r_count;
`endif

endmodule

// File: tb/tb_cordic_quad_restore.sv
// Self-checking bench for cordic_quad_restore (W=24, DEPTH=4).
module tb_cordic_quad_restore;
    localparam int W     = 24;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    cordic_quad_restore_if #(.W(W), .DEPTH(DEPTH)) bus ();

    cordic_quad_restore #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and initial input levels.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: {quad, cos, sin} expected per accepted result.
    logic [2*W+1:0] exp_q[$];
    // Reference FIFO and flag model.
    logic [1:0]     m_tags[$];
    logic           m_ovf;
    logic           m_unf;

    function automatic logic [W-1:0] exp_neg(input logic [W-1:0] x);
        if (x == 24'h800000) return 24'h7FFFFF;
        return 24'h000000 - x;
    endfunction

    // Drives one cycle, updates the model, then checks out_valid and the
    // scoreboard entry at the following negedge.
    task automatic do_cycle(input logic tv, input logic [1:0] tq, input logic rv,
                            input logic [W-1:0] c, input logic [W-1:0] s);
        logic           pop;
        logic [1:0]     q;
        logic [W-1:0]   ec;
        logic [W-1:0]   es;
        logic [2*W+1:0] e;
        bus.tag_valid = tv;
        bus.tag_quad  = tq;
        bus.res_valid = rv;
        bus.cos_in    = c;
        bus.sin_in    = s;
        pop = rv && (m_tags.size() > 0);
        if (pop) begin
            q  = m_tags.pop_front();
            ec = q[0] ? exp_neg(c) : c;
            es = q[1] ? exp_neg(s) : s;
            exp_q.push_back({q, ec, es});
        end else if (rv) begin
            m_unf = 1'b1;
        end
        if (tv && (m_tags.size() < DEPTH || pop)) m_tags.push_back(tq);
        else if (tv) m_ovf = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== pop) begin
            n_fail++;
            $display("FAIL out_valid: got %b want %b at %0t", bus.out_valid, pop, $time);
        end
        if (pop) begin
            e = exp_q.pop_front();
            if (bus.out_valid === 1'b1) begin
                n_tests++;
                if ({bus.quad_out, bus.cos_out, bus.sin_out} !== e) begin
                    n_fail++;
                    $display("FAIL result: got q=%b c=%h s=%h want q=%b c=%h s=%h",
                             bus.quad_out, bus.cos_out, bus.sin_out,
                             e[2*W+1:2*W], e[2*W-1:W], e[W-1:0]);
                end
            end
        end
        bus.tag_valid = 1'b0;
        bus.res_valid = 1'b0;
    endtask

    task automatic idle();
        do_cycle(1'b0, 2'b00, 1'b0, '0, '0);
    endtask

    // One reset cycle; tag_valid/res_valid are held high to show they are ignored.
    task automatic do_reset();
        rst           = 1'b1;
        bus.tag_valid = 1'b1;
        bus.tag_quad  = 2'b01;
        bus.res_valid = 1'b1;
        bus.cos_in    = 24'h123456;
        bus.sin_in    = 24'h654321;
        m_tags.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rst           = 1'b0;
        bus.tag_valid = 1'b0;
        bus.res_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests += 7;
        if (bus.out_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        if (bus.cos_out !== 24'h0)      begin n_fail++; $display("FAIL rst_cos: got %h want 0", bus.cos_out); end
        if (bus.sin_out !== 24'h0)      begin n_fail++; $display("FAIL rst_sin: got %h want 0", bus.sin_out); end
        if (bus.quad_out !== 2'b00)     begin n_fail++; $display("FAIL rst_quad: got %b want 00", bus.quad_out); end
        if (bus.tag_full !== 1'b0)      begin n_fail++; $display("FAIL rst_full: got %b want 0", bus.tag_full); end
        if (bus.err_overflow !== 1'b0)  begin n_fail++; $display("FAIL rst_ovf: got %b want 0", bus.err_overflow); end
        if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL rst_unf: got %b want 0", bus.err_underflow); end
    endtask

    task automatic test_basic();
        do_cycle(1'b1, 2'b00, 1'b0, '0, '0);
        do_cycle(1'b0, 2'b00, 1'b1, 24'h200000, 24'h000000);
        n_tests += 3;
        if (bus.cos_out !== 24'h200000) begin n_fail++; $display("FAIL basic_cos: got %h want 200000", bus.cos_out); end
        if (bus.sin_out !== 24'h000000) begin n_fail++; $display("FAIL basic_sin: got %h want 000000", bus.sin_out); end
        if (bus.quad_out !== 2'b00)     begin n_fail++; $display("FAIL basic_quad: got %b want 00", bus.quad_out); end
        idle();
        n_tests++;
        if (bus.cos_out !== 24'h200000) begin n_fail++; $display("FAIL hold_cos: got %h want 200000", bus.cos_out); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] want_c[3];
        logic [W-1:0] want_s[3];
        want_c = '{24'hE44986, 24'h1BB67A, 24'hE44986};
        want_s = '{24'h100000, 24'hF00000, 24'hF00000};
        do_cycle(1'b1, 2'b01, 1'b0, '0, '0);
        do_cycle(1'b1, 2'b10, 1'b0, '0, '0);
        do_cycle(1'b1, 2'b11, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 2'b00, 1'b1, 24'h1BB67A, 24'h100000);
            n_tests += 2;
            if (bus.cos_out !== want_c[i]) begin n_fail++; $display("FAIL b2b_cos%0d: got %h want %h", i, bus.cos_out, want_c[i]); end
            if (bus.sin_out !== want_s[i]) begin n_fail++; $display("FAIL b2b_sin%0d: got %h want %h", i, bus.sin_out, want_s[i]); end
        end
        idle();
    endtask

    task automatic test_overflow();
        logic [1:0] tags[5];
        tags = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, tags[i], 1'b0, '0, '0);
            if (i == 2) begin
                n_tests++;
                if (bus.tag_full !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b want 0", bus.tag_full); end
            end
            if (i == 3) begin
                n_tests += 2;
                if (bus.tag_full !== 1'b1)     begin n_fail++; $display("FAIL full_set: got %b want 1", bus.tag_full); end
                if (bus.err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", bus.err_overflow); end
            end
        end
        n_tests++;
        if (bus.err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", bus.err_overflow); end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 2'b00, 1'b1, W'($urandom_range(0, 24'h3FFFFF)), W'($urandom_range(0, 24'h3FFFFF)));
            n_tests++;
            if (bus.quad_out !== tags[i]) begin n_fail++; $display("FAIL ovf_order%0d: got %b want %b", i, bus.quad_out, tags[i]); end
            if (i == 0) begin
                n_tests++;
                if (bus.tag_full !== 1'b0) begin n_fail++; $display("FAIL full_clear: got %b want 0", bus.tag_full); end
            end
        end
        idle();
    endtask

    task automatic test_underflow();
        do_reset();
        do_cycle(1'b1, 2'b11, 1'b1, 24'h111111, 24'h222222);
        n_tests++;
        if (bus.err_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set: got %b want 1", bus.err_underflow); end
        do_cycle(1'b0, 2'b00, 1'b1, 24'h100000, 24'h123456);
        n_tests += 3;
        if (bus.quad_out !== 2'b11)     begin n_fail++; $display("FAIL unf_tag: got %b want 11", bus.quad_out); end
        if (bus.cos_out !== 24'hF00000) begin n_fail++; $display("FAIL unf_cos: got %h want F00000", bus.cos_out); end
        if (bus.sin_out !== 24'hEDCBAA) begin n_fail++; $display("FAIL unf_sin: got %h want EDCBAA", bus.sin_out); end
    endtask

    task automatic test_saturation();
        do_cycle(1'b1, 2'b11, 1'b0, '0, '0);
        do_cycle(1'b1, 2'b01, 1'b1, 24'h800000, 24'h800000);
        n_tests += 2;
        if (bus.cos_out !== 24'h7FFFFF) begin n_fail++; $display("FAIL sat_cos: got %h want 7FFFFF", bus.cos_out); end
        if (bus.sin_out !== 24'h7FFFFF) begin n_fail++; $display("FAIL sat_sin: got %h want 7FFFFF", bus.sin_out); end
        do_cycle(1'b0, 2'b00, 1'b1, 24'h800000, 24'h800000);
        n_tests += 2;
        if (bus.cos_out !== 24'h7FFFFF) begin n_fail++; $display("FAIL sat01_cos: got %h want 7FFFFF", bus.cos_out); end
        if (bus.sin_out !== 24'h800000) begin n_fail++; $display("FAIL sat01_sin: got %h want 800000", bus.sin_out); end
        idle();
    endtask

    task automatic test_reset_mid();
        do_cycle(1'b1, 2'b01, 1'b0, '0, '0);
        do_cycle(1'b1, 2'b10, 1'b0, '0, '0);
        do_reset();
        n_tests += 2;
        if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL mid_unf_clr: got %b want 0", bus.err_underflow); end
        if (bus.out_valid !== 1'b0)     begin n_fail++; $display("FAIL mid_valid: got %b want 0", bus.out_valid); end
        do_cycle(1'b0, 2'b00, 1'b1, 24'h100000, 24'h100000);
        n_tests++;
        if (bus.err_underflow !== 1'b1) begin n_fail++; $display("FAIL mid_unf_set: got %b want 1", bus.err_underflow); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            n_tests += 3;
            if (bus.tag_full !== (m_tags.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full: got %b at %0d", bus.tag_full, i); end
            if (bus.err_overflow !== m_ovf)  begin n_fail++; $display("FAIL rnd_ovf: got %b want %b", bus.err_overflow, m_ovf); end
            if (bus.err_underflow !== m_unf) begin n_fail++; $display("FAIL rnd_unf: got %b want %b", bus.err_underflow, m_unf); end
        end
        idle();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries want 0", exp_q.size()); end
    endtask

    // Test sequence and final report.
    initial begin
        rst           = 1'b1;
        bus.tag_valid = 1'b0;
        bus.tag_quad  = 2'b00;
        bus.res_valid = 1'b0;
        bus.cos_in    = '0;
        bus.sin_in    = '0;
`ifdef CORDIC_QUAD_LEVEL_EN
        bus.err_clr   = 1'b0;
`endif
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_saturation();
        test_reset_mid();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
